r_ptr_level: RTL

R_PTR_LEVEL -- requirements
Module: r_ptr_level

---
 rtl/r_ptr_level.sv | 74 +++++++
 1 files changed

// File: rtl/r_ptr_level.sv
// Read-side pointer and fill-level tracker for an async FIFO.
// Keeps the binary/Gray read pointer, empty/almost-empty flags and level.
module r_ptr_level #(
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  r_clk,
    input  logic                  r_rst,
    input  logic                  r_en,
    input  logic [ADDR_WIDTH:0]   r_q2_wptr,
    input  logic [ADDR_WIDTH:0]   r_ae_thresh,
    input  logic                  r_uf_clr,
    output logic [ADDR_WIDTH:0]   r_ptr,
    output logic [ADDR_WIDTH-1:0] r_addr,
    output logic                  empty,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   r_level,
    output logic                  underflow
);

    logic [ADDR_WIDTH:0] bin;
    logic [ADDR_WIDTH:0] bin_next;
    logic [ADDR_WIDTH:0] gray_next;
    logic [ADDR_WIDTH:0] wbin;
    logic [ADDR_WIDTH:0] level_next;
    logic                pop;

    assign pop    = r_en & ~empty;
    assign r_addr = bin[ADDR_WIDTH-1:0];

    // Next read pointer, its Gray form and the resulting fill level.
    always_comb begin
        bin_next   = bin + {{ADDR_WIDTH{1'b0}}, pop};
        gray_next  = bin_next ^ (bin_next >> 1);
        level_next = wbin - bin_next;
    end

    // Gray-to-binary of the synchronised write pointer, MSB downwards.
    always_comb begin
        wbin             = '0;
        wbin[ADDR_WIDTH] = r_q2_wptr[ADDR_WIDTH];
        for (int i = ADDR_WIDTH - 1; i >= 0; i--) begin
            wbin[i] = wbin[i+1] ^ r_q2_wptr[i];
        end
    end

    // Pointer, level and status flags, all registered together.
    always_ff @(posedge r_clk) begin
        if (r_rst) begin
            bin          <= '0;
            r_ptr        <= '0;
            r_level      <= '0;
            empty        <= 1'b1;
            almost_empty <= 1'b1;
        end else begin
            bin          <= bin_next;
            r_ptr        <= gray_next;
            r_level      <= level_next;
            empty        <= (gray_next == r_q2_wptr);
            almost_empty <= (level_next <= r_ae_thresh);
        end
    end

    // Sticky underflow: a read on empty wins over a same-cycle clear.
    always_ff @(posedge r_clk) begin
        if (r_rst) begin
            underflow <= 1'b0;
        end else if (r_en & empty) begin
            underflow <= 1'b1;
        end else if (r_uf_clr) begin
            underflow <= 1'b0;
        end
    end

endmodule
